// File: rtl/connect_frame_length_wide.sv
// Prepends a little-endian, zero-padded frame-length header (HEADER_BEATS beats) to each AXI4-Stream frame.
// Optional byte-count checking against the supplied length: define CONNECT_FRAME_LENGTH_CHECK_EN.
module connect_frame_length_wide #(
    parameter int DATA_WIDTH         = 8,
    parameter int FRAME_LENGTH_WIDTH = 16,
    parameter int KEEP_WIDTH         = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
    input  logic                          s_axis_frame_length_tvalid,
    output logic                          s_axis_frame_length_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          length_error,
    output logic [15:0]                   length_error_count
);
    localparam int HEADER_BEATS = (FRAME_LENGTH_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CNT_W        = (HEADER_BEATS > 1) ? $clog2(HEADER_BEATS) : 1;
    localparam int PAD_W        = HEADER_BEATS * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, HEADER, FRAME} state_t;

    state_t                        state, state_nx;
    logic [FRAME_LENGTH_WIDTH-1:0] len_q;
    logic [CNT_W-1:0]              hdr_cnt;
    logic [PAD_W-1:0]              hdr_pad;

    // Length zero-extended to a whole number of beats so every header slice is in range.
    always_comb begin
        hdr_pad                         = '0;
        hdr_pad[FRAME_LENGTH_WIDTH-1:0] = len_q;
    end

    always_comb begin
        state_nx                   = state;
        s_axis_frame_length_tready = 1'b0;
        s_axis_tready              = 1'b0;
        m_axis_tvalid              = 1'b0;
        m_axis_tdata               = '0;
        m_axis_tkeep               = '0;
        m_axis_tlast               = 1'b0;
        case (state)
            IDLE: begin
                s_axis_frame_length_tready = 1'b1;
                if (s_axis_frame_length_tvalid) state_nx = HEADER;
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_pad[int'(hdr_cnt)*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep  = '1;
                if (m_axis_tready && hdr_cnt == CNT_W'(HEADER_BEATS - 1)) state_nx = FRAME;
            end
            FRAME: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Nothing handshakes while reset is held.
        if (!rstn) begin
            s_axis_frame_length_tready = 1'b0;
            s_axis_tready              = 1'b0;
            m_axis_tvalid              = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            len_q   <= '0;
            hdr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && s_axis_frame_length_tvalid) begin
                len_q   <= s_axis_frame_length_tdata;
                hdr_cnt <= '0;
            end else if (state == HEADER && m_axis_tready) begin
                hdr_cnt <= hdr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CONNECT_FRAME_LENGTH_CHECK_EN
    logic [FRAME_LENGTH_WIDTH-1:0] byte_cnt, byte_sum;

    function automatic logic [FRAME_LENGTH_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [FRAME_LENGTH_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) n = n + FRAME_LENGTH_WIDTH'(k[i]);
        return n;
    endfunction

    // Running total including the current beat; wraps modulo 2^FRAME_LENGTH_WIDTH.
    always_comb byte_sum = byte_cnt + popcount(s_axis_tkeep);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt           <= '0;
            length_error       <= 1'b0;
            length_error_count <= '0;
        end else begin
            length_error <= 1'b0;
            if (state == IDLE) begin
                byte_cnt <= '0;
            end else if (state == FRAME && s_axis_tvalid && s_axis_tready) begin
                byte_cnt <= byte_sum;
                if (s_axis_tlast && byte_sum != len_q) begin
                    length_error <= 1'b1;
                    if (length_error_count != 16'hFFFF) length_error_count <= length_error_count + 16'd1;
                end
            end
        end
    end
`else
    assign length_error       = 1'b0;
    assign length_error_count = '0;
`endif

endmodule

// File: tb/tb_connect_frame_length_wide.sv
// Bench for connect_frame_length_wide at DATA_WIDTH=16, FRAME_LENGTH_WIDTH=24 (two header beats, upper one zero-padded).
// A queue-based frame model predicts every output beat and each length_error pulse.
module tb_connect_frame_length_wide;
    localparam int DW  = 16;
    localparam int FLW = 24;
    localparam int KW  = DW / 8;
`ifdef CONNECT_FRAME_LENGTH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          e;
    } beat_t;

    logic           clk, rstn;
    logic [DW-1:0]  s_data;
    logic [KW-1:0]  s_keep;
    logic           s_valid, s_ready, s_last;
    logic [FLW-1:0] l_data;
    logic           l_valid, l_ready;
    logic [DW-1:0]  m_data;
    logic [KW-1:0]  m_keep;
    logic           m_valid, m_ready, m_last;
    logic           len_err;
    logic [15:0]    err_cnt;

    connect_frame_length_wide #(.DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(FLW)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .s_axis_frame_length_tdata(l_data), .s_axis_frame_length_tvalid(l_valid),
        .s_axis_frame_length_tready(l_ready),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last),
        .length_error(len_err), .length_error_count(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    beat_t          exp_q[$];
    beat_t          frm_src[$];
    logic [FLW-1:0] len_src[$];
    logic [DW-1:0]  log_q[$];
    bit             l_fire, s_fire, rnd;
    bit             err_pend, prev_stall;
    int             exp_cnt;
    logic [DW+KW:0] prev_beat;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Model of one frame: header = length split little-endian into DW-bit beats, then the body untouched.
    task automatic push_frame(input logic [FLW-1:0] len, input int nbytes, input logic [7:0] seed);
        beat_t b;
        int nb;
        len_src.push_back(len);
        for (int i = 0; i < 2; i++) begin
            b.d = 16'(len >> (16 * i));
            b.k = 2'b11; b.l = 1'b0; b.e = 1'b0;
            exp_q.push_back(b);
        end
        nb = (nbytes + 1) / 2;
        for (int j = 0; j < nb; j++) begin
            b.d = {8'(seed + 2 * j + 1), 8'(seed + 2 * j)};
            b.k = (2 * j + 1 < nbytes) ? 2'b11 : 2'b01;
            b.l = (j == nb - 1);
            b.e = b.l && CHK && (int'(len) != nbytes);
            frm_src.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic flush();
        len_src.delete(); frm_src.delete(); exp_q.delete();
        l_valid = 1'b0; s_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((len_src.size() != 0 || frm_src.size() != 0 || exp_q.size() != 0 || l_valid || s_valid)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), budget);
            flush();
        end
        repeat (3) @(posedge clk);
    endtask

    // Source drivers: hold each item until its handshake, optionally with random gaps.
    initial begin
        l_valid = 0; s_valid = 0; l_data = '0; s_data = '0; s_keep = '0; s_last = 0; m_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (l_fire && len_src.size() != 0) begin void'(len_src.pop_front()); l_valid = 0; end
            if (s_fire && frm_src.size() != 0) begin void'(frm_src.pop_front()); s_valid = 0; end
            if (!l_valid && len_src.size() != 0 && (!rnd || $urandom_range(1) == 1)) begin
                l_valid = 1; l_data = len_src[0];
            end
            if (!s_valid && frm_src.size() != 0 && (!rnd || $urandom_range(1) == 1)) begin
                s_valid = 1; s_data = frm_src[0].d; s_keep = frm_src[0].k; s_last = frm_src[0].l;
            end
            m_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Compare process: every output handshake, stall stability, error pulse and counter.
    always @(negedge clk) begin
        beat_t e;
        l_fire = l_valid && l_ready;
        s_fire = s_valid && s_ready;
        if (!rstn) begin
            prev_stall = 0; err_pend = 0;
        end else begin
            if (err_pend && exp_cnt < 16'hFFFF) exp_cnt++;
            chk("length_error", 64'(len_err), 64'(err_pend));
            chk("length_error_count", 64'(err_cnt), 64'(exp_cnt));
            err_pend = 0;
            if (prev_stall)
                chk("stall_hold", 64'({m_valid, m_data, m_keep, m_last}), 64'({1'b1, prev_beat}));
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_data, m_keep, m_last};
            if (m_valid && m_ready) begin
                log_q.push_back(m_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'({m_data, m_keep, m_last}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 64'({m_data, m_keep, m_last}), 64'({e.d, e.k, e.l}));
                    err_pend = e.e;
                end
            end
        end
    end

    initial begin
        rnd = 0; exp_cnt = 0; rstn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_len_tready", 64'(l_ready), 64'(0));
        chk("rst_s_tready", 64'(s_ready), 64'(0));
        chk("rst_m_tvalid", 64'(m_valid), 64'(0));
        chk("rst_error", 64'(len_err), 64'(0));
        chk("rst_error_count", 64'(err_cnt), 64'(0));
        @(posedge clk); #2 rstn = 1;
        @(negedge clk);
        chk("idle_len_tready", 64'(l_ready), 64'(1));
        chk("idle_s_tready", 64'(s_ready), 64'(0));

        // Three header bytes over two 16-bit beats: 0x05DC then zero-padded 0x0001.
        log_q.delete();
        push_frame(24'h0105DC, 6, 8'h10);
        wait_drain(200);
        chk("hdr0_0105DC", 64'(log_q.size() > 0 ? log_q[0] : 16'hXXXX), 64'h05DC);
        chk("hdr1_0105DC", 64'(log_q.size() > 1 ? log_q[1] : 16'hXXXX), 64'h0001);
        chk("body0_0105DC", 64'(log_q.size() > 2 ? log_q[2] : 16'hXXXX), 64'h1110);
        chk("beats_0105DC", 64'(log_q.size()), 64'd5);
        chk("count_after_short", 64'(err_cnt), CHK ? 64'd1 : 64'd0);

        // Full-size frame, matching length.
        log_q.delete();
        push_frame(24'd1518, 1518, 8'h00);
        wait_drain(2000);
        chk("hdr0_1518", 64'(log_q.size() > 0 ? log_q[0] : 16'hXXXX), 64'h05EE);
        chk("hdr1_1518", 64'(log_q.size() > 1 ? log_q[1] : 16'hXXXX), 64'h0000);
        chk("beats_1518", 64'(log_q.size()), 64'd761);
        chk("last_1518", 64'(log_q.size() > 0 ? log_q[log_q.size()-1] : 16'hXXXX), 64'hEDEC);

        // Length 60 against a 64-byte body.
        log_q.delete();
        push_frame(24'd60, 64, 8'h40);
        wait_drain(200);
        chk("beats_60v64", 64'(log_q.size()), 64'd34);
        chk("count_after_60v64", 64'(err_cnt), CHK ? 64'd2 : 64'd0);

        // Odd length (partial last keep) and back-to-back tiny frames.
        push_frame(24'd61, 61, 8'h80);
        push_frame(24'd1, 1, 8'hA0);
        push_frame(24'd2, 2, 8'hB0);
        push_frame(24'd3, 3, 8'hC0);
        wait_drain(300);
        chk("count_after_matched", 64'(err_cnt), CHK ? 64'd2 : 64'd0);

        // Random source gaps and sink back-pressure, occasional wrong lengths.
        rnd = 1;
        for (int f = 0; f < 100; f++) begin
            int nb;
            nb = $urandom_range(40, 1);
            push_frame(($urandom_range(7) == 0) ? 24'(nb + 1) : 24'(nb), nb, 8'($urandom));
        end
        wait_drain(20000);
        rnd = 0;
        repeat (2) @(posedge clk);

        // Reset during a frame body abandons it; the next pair must come out clean.
        push_frame(24'd40, 40, 8'h20);
        for (int n = 0; n < 200 && exp_q.size() > 10; n++) @(posedge clk);
        @(posedge clk); #2;
        rstn = 0; flush(); exp_cnt = 0;
        @(negedge clk);
        chk("midrst_m_tvalid", 64'(m_valid), 64'(0));
        chk("midrst_s_tready", 64'(s_ready), 64'(0));
        @(posedge clk); #2 rstn = 1;
        @(negedge clk);
        chk("postrst_idle", 64'(l_ready), 64'(1));
        chk("postrst_m_tvalid", 64'(m_valid), 64'(0));
        chk("postrst_count", 64'(err_cnt), 64'(0));
        log_q.delete();
        push_frame(24'h000010, 16, 8'h30);
        wait_drain(200);
        chk("hdr0_after_rst", 64'(log_q.size() > 0 ? log_q[0] : 16'hXXXX), 64'h0010);
        chk("hdr1_after_rst", 64'(log_q.size() > 1 ? log_q[1] : 16'hXXXX), 64'h0000);
        chk("beats_after_rst", 64'(log_q.size()), 64'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/connect_frame_length_wide.md
# connect_frame_length_wide

Prepends a frame-length header to each Ethernet frame on an AXI4-Stream. The length arrives as one wide beat on a side stream; the block serialises it into one or more header beats ahead of the frame. It generalises the 8-bit connector: any byte-multiple data width, any header width, and optional byte-count checking of the frame against the supplied length. It sits between the frame source (MAC receive path or parser) and the queueing/ATS logic that expects a `[frame length]/[Ethernet frame]` stream.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: data bus width; must be a multiple of 8.
- `FRAME_LENGTH_WIDTH`, default 16: length field width; must be a multiple of 8.
- `KEEP_WIDTH`, default `DATA_WIDTH/8`: tkeep width.
- `HEADER_BEATS`, derived as `ceil(FRAME_LENGTH_WIDTH/DATA_WIDTH)`: number of output header beats.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `s_axis_tdata/tkeep/tvalid/tready/tlast`  in/in/in/out/in  DATA_WIDTH/KEEP_WIDTH/1/1/1  frame stream without header.
- `s_axis_frame_length_tdata`  in  FRAME_LENGTH_WIDTH  frame length in bytes; one beat per frame.
- `s_axis_frame_length_tvalid`  in  1, and `s_axis_frame_length_tready`  out  1  length handshake.
- `m_axis_tdata/tkeep/tvalid/tready/tlast`  out/out/out/in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1  header followed by frame.
- `length_error`  out  1  one-cycle pulse when a length mismatch is detected.
- `length_error_count`  out  16  saturating mismatch counter.

## Operation

- FSM states: IDLE, HEADER, FRAME.
- **IDLE**
  - `s_axis_frame_length_tready`=1, `s_axis_tready`=0, `m_axis_tvalid`=0.
  - On a length handshake: latch tdata into `len_q`, clear `hdr_cnt`, go to HEADER.
- **HEADER**
  - `m_axis_tvalid`=1.
  - `m_axis_tdata` = `len_q >> (DATA_WIDTH*hdr_cnt)`, truncated to DATA_WIDTH; bits beyond FRAME_LENGTH_WIDTH are zero (little-endian, zero-padded).
  - `m_axis_tkeep` = all ones; `m_axis_tlast`=0.
  - `hdr_cnt` increments on each `m_axis` handshake.
  - A handshake with `hdr_cnt==HEADER_BEATS-1` moves to FRAME.
  - Both slave treadys are 0.
- **FRAME**
  - Combinational pass-through: `m_axis_{tdata,tkeep,tvalid,tlast}` = `s_axis_*`, and `s_axis_tready` = `m_axis_tready`.
  - A handshake with `tlast`=1 returns to IDLE.
  - `s_axis_frame_length_tready`=0.
- The length beat is accepted only in IDLE. A frame beat that arrives early is held off by `s_axis_tready`=0.
- The frame stream carries no length information. A frame always consumes exactly one length beat, taken in order.

## Timing

- Reset values:
  - State IDLE; `len_q`=0; `hdr_cnt`=0.
  - `m_axis_tvalid`=0; `s_axis_tready`=0; `s_axis_frame_length_tready`=0 while `rstn`=0.
  - `length_error`=0; `length_error_count`=0.
- Latency:
  - Length handshake at cycle N → first header beat valid at N+1.
  - Frame beats have zero latency in FRAME.
- Minimum cost: 1 IDLE cycle plus HEADER_BEATS cycles per frame, with no frame overlap.
- Header beats remain stable while `m_axis_tready`=0 (AXI hold rule).
- Reset mid-operation: return to IDLE the next edge. A partially sent frame is abandoned; there is no tlast cleanup.
- Length and frame data presented in the same cycle: the length is taken first, and the frame waits until FRAME.

## Configuration

- Macro: `CONNECT_FRAME_LENGTH_CHECK_EN`.
- **Defined:**
  - In FRAME, a FRAME_LENGTH_WIDTH-bit byte counter adds popcount(`s_axis_tkeep`) on each handshake; it wraps modulo 2^FRAME_LENGTH_WIDTH.
  - On the tlast handshake, the final count (including that beat) is compared to `len_q`.
  - On a mismatch, `length_error` pulses high for exactly one cycle, the cycle after the tlast handshake.
  - `length_error_count` increments and saturates at 0xFFFF.
  - The data stream is never altered.
- **Undefined:** no counter logic; `length_error` and `length_error_count` are tied to 0.

## Test plan

- DW=8, FLW=16, length 1518, 1518-byte frame:
  - output beats 0xEE, 0x05, then 1518 frame bytes, last with tlast;
  - `length_error` stays 0.
- DW=64, FLW=16, length 64:
  - header is a single beat, tdata=0x0000_0000_0000_0040, tkeep=0xFF, tlast=0;
  - followed by 8 frame beats.
- DW=8, FLW=24, length 0x0105DC:
  - header beats 0xDC, 0x05, 0x01;
  - frame follows.
- Random 50% `m_axis_tready` and `s_axis_tvalid` over 100 frames:
  - output matches the pcap with the prepended lengths;
  - header data is stable under stall.
- With CHECK_EN, length 60 and a 64-byte frame:
  - `length_error` is a single-cycle pulse;
  - `length_error_count`=1;
  - output data is unchanged.
- `rstn` low for 1 cycle during the frame body:
  - next cycle: IDLE, `m_axis_tvalid`=0;
  - the next length/frame pair is processed correctly.
